// File: rtl/nco_phase_acc_if.sv
// Angle stream port between the phase accumulator and the nco.
// The producer drives dat/req and the consumer answers with ack.
interface nco_phase_acc_if #(
    parameter int AW = 32
);
    logic [AW-1:0] dat;
    logic          req;
    logic          ack;

    modport master (
        output dat,
        output req,
        input  ack
    );

    modport slave (
        input  dat,
        input  req,
        output ack
    );
endinterface

// File: rtl/nco_phase_acc.sv
// Phase-accumulator front end for the nco pipeline.
// Produces a stream of AW-bit angles for continuous tones and linear chirps.
// Retuning and sweep wrap-around keep the phase continuous.
// Every output is a flop, so there is no combinational path from ack to req or dat.
module nco_phase_acc #(
    parameter int AW = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           cfg_mode,
    input  logic [AW-1:0]        cfg_ftw,
    input  logic [AW-1:0]        cfg_dftw,
    input  logic [AW-1:0]        cfg_ftw_end,
    input  logic [AW-1:0]        cfg_ofs,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sync,
    input  logic                 cfg_upd,
    nco_phase_acc_if.master      i_angle,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nxt;

    logic [AW-1:0] acc, acc_nxt;
    logic [AW-1:0] ftw_r, ftw_nxt;
    logic [AW-1:0] ftw_start_r, ftw_start_nxt;
    logic [AW-1:0] dftw_r, dftw_nxt;
    logic [AW-1:0] end_r, end_nxt;
    logic [AW-1:0] ofs_r, ofs_nxt;
    logic [1:0]    mode_r, mode_nxt;
    logic          sync_pend, sync_pend_nxt;
    logic          stop_pend, stop_pend_nxt;
    logic [AW-1:0] dat_r, dat_nxt;
    logic          req_r, req_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    logic          xfer;
    logic          sweep;
    logic          terminal;
    logic          last_xfer;

    assign i_angle.dat = dat_r;
    assign i_angle.req = req_r;

    // Handshake and sweep-end detection; mode 3 behaves like continuous mode.
    assign xfer      = req_r & i_angle.ack;
    assign sweep     = (mode_r == 2'd1) || (mode_r == 2'd2);
    assign terminal  = sweep && (dftw_r[AW-1] ? ($signed(ftw_r) <= $signed(end_r))
                                              : ($signed(ftw_r) >= $signed(end_r)));
    assign last_xfer = xfer && (stop_pend || stop || (terminal && (mode_r == 2'd1)));

    // State register plus all datapath/output flops, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            acc         <= '0;
            ftw_r       <= '0;
            ftw_start_r <= '0;
            dftw_r      <= '0;
            end_r       <= '0;
            ofs_r       <= '0;
            mode_r      <= 2'd0;
            sync_pend   <= 1'b0;
            stop_pend   <= 1'b0;
            dat_r       <= '0;
            req_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            ftw_r       <= ftw_nxt;
            ftw_start_r <= ftw_start_nxt;
            dftw_r      <= dftw_nxt;
            end_r       <= end_nxt;
            ofs_r       <= ofs_nxt;
            mode_r      <= mode_nxt;
            sync_pend   <= sync_pend_nxt;
            stop_pend   <= stop_pend_nxt;
            dat_r       <= dat_nxt;
            req_r       <= req_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state logic: start leaves IDLE, the last transfer of a run returns to it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the accumulator, tuning word, pending flags and registered outputs.
    always_comb begin
        acc_nxt       = acc;
        ftw_nxt       = ftw_r;
        ftw_start_nxt = ftw_start_r;
        dftw_nxt      = dftw_r;
        end_nxt       = end_r;
        ofs_nxt       = ofs_r;
        mode_nxt      = mode_r;
        sync_pend_nxt = sync_pend;
        stop_pend_nxt = stop_pend;
        dat_nxt       = dat_r;
        req_nxt       = req_r;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ftw_nxt       = cfg_ftw;
                    ftw_start_nxt = cfg_ftw;
                    dftw_nxt      = cfg_dftw;
                    end_nxt       = cfg_ftw_end;
                    ofs_nxt       = cfg_ofs;
                    mode_nxt      = cfg_mode;
                    acc_nxt       = '0;
                    dat_nxt       = cfg_ofs;
                    req_nxt       = 1'b1;
                    busy_nxt      = 1'b1;
                    sync_pend_nxt = 1'b0;
                    stop_pend_nxt = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_nxt       = (sync_pend || sync) ? '0 : acc + ftw_r;
                    dat_nxt       = acc_nxt + ofs_r;
                    sync_pend_nxt = 1'b0;
                    if (sweep) begin
                        if (terminal) begin
                            done_nxt = 1'b1;
                            if (mode_r == 2'd2) ftw_nxt = ftw_start_r;
                        end else begin
                            ftw_nxt = ftw_r + dftw_r;
                        end
                    end
                    if (last_xfer) begin
                        req_nxt       = 1'b0;
                        busy_nxt      = 1'b0;
                        stop_pend_nxt = 1'b0;
                    end
                end else begin
                    if (sync) sync_pend_nxt = 1'b1;
                    if (stop) stop_pend_nxt = 1'b1;
                end
                if (cfg_upd && !sweep) ftw_nxt = cfg_ftw;
            end
            default: ;
        endcase
    end

endmodule
